l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single unified L2 cache port between the instruction-side L1 (I) and the data-side L1 (D).
- Sits between both L1 miss interfaces and the L2 cpu-side interface: mem_read, mem_write, mem_address, 256-bit data, mem_resp.
- Selects one requester, registers its request, and holds it stable on the L2 port until mem_resp.
- Routes the response back to the selected requester only. D has priority; a streak limit prevents I starvation.

Parameters:
- s_line, 256, cache line width in bits (data bus width on all ports).
- max_d_streak, 4, maximum consecutive D grants while I is waiting; the next grant then goes to I.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low (rst==0 resets on the rising clk edge).
- i_read  input  1  I-side line read request.
- i_address  input  32  I-side line address.
- i_resp  output  1  I-side response.
- i_rdata256  output  s_line  I-side read data.
- d_read  input  1  D-side line read request.
- d_write  input  1  D-side line write-back request.
- d_address  input  32  D-side line address.
- d_wdata256  input  s_line  D-side write data.
- d_resp  output  1  D-side response.
- d_rdata256  output  s_line  D-side read data.
- l2_read  output  1  read request to L2.
- l2_write  output  1  write request to L2.
- l2_address  output  32  address to L2.
- l2_wdata256  output  s_line  write data to L2.
- l2_rdata256  input  s_line  read data from L2.
- l2_resp  input  1  L2 response, one-cycle pulse.

Behaviour:
- Reset values:
  - All registered outputs 0: l2_read, l2_write, l2_address, l2_wdata256.
  - State IDLE, streak counter 0.
  - i_resp and d_resp are 0 because the state is not BUSY.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, request pending:
  - D pending = d_read|d_write. I pending = i_read.
  - If D pending and not (I pending and streak==max_d_streak): grant D.
    - Register l2_address=d_address and l2_wdata256=d_wdata256.
    - Register l2_write=d_write and l2_read=d_read&~d_write (write wins if both are set).
    - Next state BUSY_D.
  - Otherwise, if I pending: grant I.
    - Register l2_address=i_address, l2_read=1, l2_write=0. l2_wdata256 is unchanged.
    - Next state BUSY_I.
- IDLE, no request: stay in IDLE; l2_read and l2_write stay 0.
- BUSY_x, waiting:
  - l2_* outputs hold their registered values every cycle until l2_resp.
  - Requester input changes are ignored.
- BUSY_x, on l2_resp:
  - The granted x_resp is asserted combinationally in the same cycle.
  - No resp is ever asserted on the non-granted side.
  - l2_read and l2_write are registered to 0 at that edge. Next state DONE.
- DONE:
  - Lasts exactly one cycle with no grant, giving the served L1 time to drop its request.
  - Next state IDLE.
- Latency:
  - Request seen in IDLE at cycle t puts l2_read or l2_write high from t+1.
  - Response at cycle r puts x_resp high at r.
  - The next grant evaluation happens at r+2.
- Read data: i_rdata256 and d_rdata256 are both driven from l2_rdata256 (pass-through). It is valid only when the matching resp is high.
- Streak counter (saturates at max_d_streak):
  - Incremented on a D grant made while i_read is high.
  - Cleared on any I grant.
  - Cleared in IDLE when i_read is low.
- Simultaneous I and D requests with streak<max: D wins and I waits.
- l2_resp seen in IDLE or DONE (spurious): ignored, no x_resp.
- Reset mid-transaction (rst low during BUSY_x):
  - The next edge returns to IDLE with l2_read and l2_write at 0.
  - A later l2_resp is ignored.
  - No x_resp is generated in the reset cycle.

Test Plan:
- I-only read:
  - Stimulus: i_read=1, i_address=0x0000_1040. L2 responds 3 cycles after l2_read with l2_rdata256=0xA5…A5.
  - Required: l2_read high the cycle after the request, l2_address=0x0000_1040. i_resp is a one-cycle pulse with i_rdata256=0xA5…A5. d_resp stays 0.
- D write-back:
  - Stimulus: d_write=1, d_address=0x8000_00E0, d_wdata256=0x1234….
  - Required: l2_write=1, l2_read=0, l2_wdata256 matches. d_resp pulses on l2_resp. Outputs stay stable throughout BUSY while d_address is changed mid-wait.
- Simultaneous requests:
  - Stimulus: i_read and d_read asserted in the same cycle.
  - Required: D is served first. After DONE, I is granted at r+2 with l2_address=i_address.
- Starvation guard:
  - Stimulus: i_read held high while D issues 6 back-to-back reads.
  - Required: D is granted 4 times, then I, then D resumes. The counter returns to 0 after the I grant.
- Edge cases:
  - Spurious l2_resp in IDLE produces no resp.
  - d_read&d_write together produce l2_write=1, l2_read=0.
- Reset mid-BUSY:
  - Stimulus: rst=0 for one cycle while in BUSY_D, then a late l2_resp.
  - Required: l2_read, l2_write and l2_address are 0 after the edge. The late l2_resp produces no d_resp.

Source files
------------

// File: rtl/l2_arbiter.sv
// Arbitrates the I-side and D-side L1 miss ports onto the single L2 port.
// Handshake: a requester holds x_read/x_write until x_resp pulses, then drops it during the following DONE cycle.
module l2_arbiter #(
    parameter int s_line       = 256,
    parameter int max_d_streak = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic              i_resp,
    output logic [s_line-1:0] i_rdata256,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [s_line-1:0] d_wdata256,
    output logic              d_resp,
    output logic [s_line-1:0] d_rdata256,
    output logic              l2_read,
    output logic              l2_write,
    output logic [31:0]       l2_address,
    output logic [s_line-1:0] l2_wdata256,
    input  logic [s_line-1:0] l2_rdata256,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

    localparam int SW = $clog2(max_d_streak + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(max_d_streak);

    state_e            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              l2_read_q, l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic [31:0]       l2_address_q, l2_address_d;
    logic [s_line-1:0] l2_wdata_q, l2_wdata_d;
    logic              d_pend, i_pend;

    assign d_pend = d_read | d_write;
    assign i_pend = i_read;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            l2_address_q <= l2_address_d;
            l2_wdata_q   <= l2_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        l2_address_d = l2_address_q;
        l2_wdata_d   = l2_wdata_q;
        case (state_q)
            IDLE: begin
                if (!i_read) begin
                    streak_d = '0;
                end
                // D wins unless I has been waiting through a full streak of D grants.
                if (d_pend && !(i_pend && streak_q == STREAK_MAX)) begin
                    l2_address_d = d_address;
                    l2_wdata_d   = d_wdata256;
                    l2_write_d   = d_write;
                    l2_read_d    = d_read & ~d_write;
                    state_d      = BUSY_D;
                    if (i_read && streak_q != STREAK_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_pend) begin
                    l2_address_d = i_address;
                    l2_read_d    = 1'b1;
                    l2_write_d   = 1'b0;
                    streak_d     = '0;
                    state_d      = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (l2_resp) begin
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Responses are gated by rst so a reset cycle never leaks a response.
    always_comb begin
        i_resp = rst && l2_resp && (state_q == BUSY_I);
        d_resp = rst && l2_resp && (state_q == BUSY_D);
    end

    assign i_rdata256  = l2_rdata256;
    assign d_rdata256  = l2_rdata256;
    assign l2_read     = l2_read_q;
    assign l2_write    = l2_write_q;
    assign l2_address  = l2_address_q;
    assign l2_wdata256 = l2_wdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: inputs driven and outputs checked on the falling edge.
module tb_l2_arbiter;

    localparam int W = 256;

    logic          clk, rst;
    logic          i_read, d_read, d_write, l2_resp;
    logic [31:0]   i_address, d_address;
    logic [W-1:0]  d_wdata256, l2_rdata256;
    logic          i_resp, d_resp, l2_read, l2_write;
    logic [W-1:0]  i_rdata256, d_rdata256, l2_wdata256;
    logic [31:0]   l2_address;

    int total  = 0;
    int passes = 0;

    l2_arbiter #(.s_line(W), .max_d_streak(4)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata256(i_rdata256),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata256(d_wdata256),
        .d_resp(d_resp), .d_rdata256(d_rdata256),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata256(l2_wdata256), .l2_rdata256(l2_rdata256), .l2_resp(l2_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic [W-1:0] pat_a5, pat_12, pat_rd;
        logic         exp_is_i [8];
        logic [31:0]  exp_addr;
        int           d_idx, i_idx;

        pat_a5 = {32{8'hA5}};
        pat_12 = {8{32'h1234_5678}};
        pat_rd = {16{16'hC3E1}};
        exp_is_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
        i_address = '0; d_address = '0; d_wdata256 = '0; l2_rdata256 = '0;
        @(negedge clk);
        tick;
        chk("rst_l2_read",  l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_l2_addr",  l2_address, 0);
        chk("rst_l2_wdata", l2_wdata256, 0);
        chk("rst_i_resp",   i_resp, 0);
        chk("rst_d_resp",   d_resp, 0);
        rst = 1'b1;
        tick;

        // I-only read, L2 answers on the third BUSY cycle
        i_read = 1'b1; i_address = 32'h0000_1040;
        tick;
        chk("i_l2_read",  l2_read, 1);
        chk("i_l2_write", l2_write, 0);
        chk("i_l2_addr",  l2_address, 32'h0000_1040);
        tick;
        tick;
        chk("i_hold_read", l2_read, 1);
        l2_resp = 1'b1; l2_rdata256 = pat_a5;
        #1;
        chk("i_resp",       i_resp, 1);
        chk("i_rdata",      i_rdata256, pat_a5);
        chk("i_no_d_resp",  d_resp, 0);
        tick;
        l2_resp = 1'b0; i_read = 1'b0;
        #1;
        chk("i_resp_pulse", i_resp, 0);
        chk("i_done_read",  l2_read, 0);
        tick;

        // D write-back with requester inputs changing mid-wait
        d_write = 1'b1; d_address = 32'h8000_00E0; d_wdata256 = pat_12;
        tick;
        chk("dw_l2_write", l2_write, 1);
        chk("dw_l2_read",  l2_read, 0);
        chk("dw_l2_addr",  l2_address, 32'h8000_00E0);
        chk("dw_l2_wdata", l2_wdata256, pat_12);
        d_address = 32'hDEAD_0000; d_wdata256 = '0; d_write = 1'b0;
        tick;
        chk("dw_hold_addr",  l2_address, 32'h8000_00E0);
        chk("dw_hold_wdata", l2_wdata256, pat_12);
        chk("dw_hold_write", l2_write, 1);
        l2_resp = 1'b1;
        #1;
        chk("dw_d_resp",    d_resp, 1);
        chk("dw_no_i_resp", i_resp, 0);
        tick;
        l2_resp = 1'b0;
        #1;
        chk("dw_done_write", l2_write, 0);
        chk("dw_resp_pulse", d_resp, 0);
        tick;

        // simultaneous I and D reads: D first, I granted at r+2
        i_read = 1'b1; i_address = 32'h0000_2000;
        d_read = 1'b1; d_address = 32'h0000_3000;
        tick;
        chk("sim_d_first", l2_address, 32'h0000_3000);
        chk("sim_d_read",  l2_read, 1);
        l2_resp = 1'b1; l2_rdata256 = pat_rd;
        #1;
        chk("sim_d_resp",  d_resp, 1);
        chk("sim_i_quiet", i_resp, 0);
        chk("sim_d_rdata", d_rdata256, pat_rd);
        tick;
        l2_resp = 1'b0; d_read = 1'b0;
        tick;
        chk("sim_idle_no_read", l2_read, 0);
        tick;
        chk("sim_i_grant", l2_address, 32'h0000_2000);
        chk("sim_i_read",  l2_read, 1);
        l2_resp = 1'b1;
        #1;
        chk("sim_i_resp", i_resp, 1);
        tick;
        l2_resp = 1'b0; i_read = 1'b0;
        tick;

        // starvation guard: I stays pending while D issues six reads
        d_idx = 0; i_idx = 0; i_read = 1'b1;
        for (int g = 0; g < 8; g++) begin
            d_read    = (d_idx < 6);
            d_address = 32'h0000_5000 + 32'(d_idx) * 32'h40;
            i_address = (i_idx == 0) ? 32'h0000_4000 : 32'h0000_4100;
            tick;
            exp_addr = exp_is_i[g] ? i_address : d_address;
            chk($sformatf("stv_addr_%0d", g), l2_address, exp_addr);
            chk($sformatf("stv_read_%0d", g), l2_read, 1);
            l2_resp = 1'b1;
            #1;
            chk($sformatf("stv_i_resp_%0d", g), i_resp, exp_is_i[g]);
            chk($sformatf("stv_d_resp_%0d", g), d_resp, !exp_is_i[g]);
            tick;
            l2_resp = 1'b0;
            if (exp_is_i[g]) i_idx++;
            else d_idx++;
            tick;
        end
        i_read = 1'b0; d_read = 1'b0;
        tick;

        // spurious response in IDLE
        l2_resp = 1'b1;
        #1;
        chk("spur_i_resp", i_resp, 0);
        chk("spur_d_resp", d_resp, 0);
        tick;
        l2_resp = 1'b0;
        chk("spur_no_read",  l2_read, 0);
        chk("spur_no_write", l2_write, 0);

        // read and write together: write wins
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_6000; d_wdata256 = pat_a5;
        tick;
        chk("rw_l2_write", l2_write, 1);
        chk("rw_l2_read",  l2_read, 0);
        d_read = 1'b0; d_write = 1'b0;

        // reset while BUSY_D, with a response in the reset cycle and a late one after
        rst = 1'b0; l2_resp = 1'b1;
        #1;
        chk("rstb_d_resp_in_rst", d_resp, 0);
        tick;
        rst = 1'b1; l2_resp = 1'b0;
        chk("rstb_l2_read",  l2_read, 0);
        chk("rstb_l2_write", l2_write, 0);
        chk("rstb_l2_addr",  l2_address, 0);
        chk("rstb_l2_wdata", l2_wdata256, 0);
        l2_resp = 1'b1;
        #1;
        chk("rstb_late_d_resp", d_resp, 0);
        chk("rstb_late_i_resp", i_resp, 0);
        tick;
        l2_resp = 1'b0;
        chk("rstb_idle_read", l2_read, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
